booth_mul_seq: RTL

- Multi-cycle signed multiplier controller. Implements radix-2 Booth by sequencing one shared (W+1)-bit ripple-carry add/sub stage over W iterations.
- The add/sub stage is an instance of the team's parameterised RCA adder with w = W+1. Its carry_in line selects the operation: 0 = add, 1 = subtract.
- Sits beside the combinational ALU ops and serves the MUL opcode. Uses a start/busy/done handshake toward the ALU control unit.

---
 rtl/booth_mul_seq.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// ----------------------------------------------------------------------------
// booth_mul_seq -- sequential radix-2 Booth signed multiplier.
//
// One shared (W+1)-bit ripple-carry add/sub stage is reused over W
// iterations. The operation follows a start/busy/done handshake toward the
// ALU control unit.
//
// Optional build macro:
//   BOOTH_SKIP_EN  when defined, an ADD-state iteration whose Booth pair is
//                  00 or 11 shifts in the same cycle, so latency varies from
//                  W+1 to 2W+1 cycles. Results are identical either way.
//
// Parameters:
//   W        operand width in bits (>= 2)
//
// Ports:
//   clk      rising-edge clock
//   rst_b    asynchronous active-low reset
//   start    request pulse, sampled only in IDLE or DONE
//   a        multiplicand, two's complement, sampled with start
//   b        multiplier, two's complement, sampled with start
//   busy     high while iterating (ADD / SHIFT)
//   done     one-cycle completion pulse
//   product  signed 2W-bit result, held until the next completion
// ----------------------------------------------------------------------------

// Parameterised ripple-carry adder. i_cin = 1 inverts i_b and adds 1, so the
// same stage performs i_a - i_b.
module rca_adder #(
    parameter int w = 9
) (
    input  logic [w-1:0] i_a,
    input  logic [w-1:0] i_b,
    input  logic         i_cin,
    output logic [w-1:0] o_sum,
    output logic         o_cout
);

    logic [w-1:0] w_b_eff;
    logic         w_carry;

    assign w_b_eff = i_b ^ {w{i_cin}};

    // Ripple the carry bit by bit from the LSB.
    always_comb begin
        w_carry = i_cin;
        o_sum   = '0;
        for (int i = 0; i < w; i++) begin
            o_sum[i] = i_a[i] ^ w_b_eff[i] ^ w_carry;
            w_carry  = (i_a[i] & w_b_eff[i]) | (w_carry & (i_a[i] ^ w_b_eff[i]));
        end
        o_cout = w_carry;
    end

endmodule

module booth_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W:0]     r_acc;
    logic [W:0]     r_mcand;
    logic [W-1:0]   r_mplier;
    logic           r_qm1;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_product;
    logic           r_busy;
    logic           r_done;

    logic [W:0]     w_sum;
    logic           w_cout_unused;
    logic           w_sub;
    logic           w_addop;
    logic           w_last;
    logic           w_load;
    logic           w_add;
    logic           w_shift;
    logic [W:0]     w_acc_sh;
    logic [W-1:0]   w_q_sh;

    // Booth pair {Q[0], q_m1}: 10 subtracts M, 01 adds M, 00/11 leaves A alone.
    assign w_sub   = r_mplier[0] & ~r_qm1;
    assign w_addop = r_mplier[0] ^ r_qm1;
    assign w_last  = (r_cnt == CNT_LAST);

    // Arithmetic right shift of {A, Q, q_m1}; A's sign bit is replicated.
    assign w_acc_sh = {r_acc[W], r_acc[W:1]};
    assign w_q_sh   = {r_acc[0], r_mplier[W-1:1]};

    rca_adder #(
        .w (W + 1)
    ) u_addsub (
        .i_a    (r_acc),
        .i_b    (r_mcand),
        .i_cin  (w_sub),
        .o_sum  (w_sum),
        .o_cout (w_cout_unused)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_add   = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = S_ADD;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ADD: begin
`ifdef BOOTH_SKIP_EN
                // Nothing to add: fold the shift into this cycle.
                if (!w_addop) begin
                    w_shift = 1'b1;
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ADD;
                    end
                end else begin
                    w_add  = 1'b1;
                    w_next = S_SHIFT;
                end
`else
                w_add  = w_addop;
                w_next = S_SHIFT;
`endif
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ADD;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Booth datapath: operand load, accumulate, shift and result latch.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_qm1     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_acc    <= '0;
            r_mcand  <= {a[W-1], a};
            r_mplier <= b;
            r_qm1    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_add) begin
            r_acc <= w_sum;
        end else if (w_shift) begin
            r_acc    <= w_acc_sh;
            r_mplier <= w_q_sh;
            r_qm1    <= r_mplier[0];
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_product <= {w_acc_sh[W-1:0], w_q_sh};
            end
        end
    end

    // Handshake flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next == S_ADD) || (w_next == S_SHIFT);
            r_done <= (w_next == S_DONE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule
